// File: rtl/mem_stage_if.sv
// Request/response bundle between the ALU stage, the data-memory stage and WriteBack.
// The master drives the i_* fields and consumes the o_* fields; the slave is the memory stage.
interface mem_stage_if;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_pc;
    logic [31:0] i_addr;
    logic [31:0] i_store_data;
    logic [2:0]  i_funct3;
    logic        i_mem_read;
    logic        i_mem_write;
    logic        i_wback;
    logic [4:0]  i_wreg;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_pc;
    logic        o_wback;
    logic [4:0]  o_wreg;
    logic [31:0] o_wdata;
    logic        o_fault;

    modport master (
        output i_valid, i_pc, i_addr, i_store_data, i_funct3,
               i_mem_read, i_mem_write, i_wback, i_wreg, i_ready,
        input  o_ready, o_valid, o_pc, o_wback, o_wreg, o_wdata, o_fault
    );

    modport slave (
        input  i_valid, i_pc, i_addr, i_store_data, i_funct3,
               i_mem_read, i_mem_write, i_wback, i_wreg, i_ready,
        output o_ready, o_valid, o_pc, o_wback, o_wreg, o_wdata, o_fault
    );
endinterface

// File: rtl/mem_stage.sv
// Data-memory pipeline stage: RV32I loads/stores against an internal synchronous RAM,
// with a fixed accept-to-valid latency for every instruction class.
module mem_stage #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_2000
) (
    input logic        clk,
    input logic        rst,
    mem_stage_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN  = 32'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state, state_nxt;
    logic        ready_q, ready_nxt;
    logic        valid_q, valid_nxt;
    logic        wback_q, wback_nxt;
    logic        fault_q, fault_nxt;
    logic [31:0] wdata_q, wdata_nxt;

    logic [31:0] req_pc, req_addr, req_sdata;
    logic [2:0]  req_f3;
    logic        req_rd, req_wr, req_wback;
    logic [4:0]  req_wreg;

    logic [31:0] ram [DEPTH_WORDS];
    logic [31:0] rdata;

    logic [31:0]      offset;
    logic [IDX_W-1:0] idx;
    logic             in_range, width_ok, aligned, fault;
    logic [3:0]       be;
    logic [31:0]      wr_data, shifted, load_data;
    logic             accept, do_write;

    assign accept   = (state == IDLE) && bus.i_valid;
    assign offset   = req_addr - BASE_ADDR;
    assign in_range = (req_addr >= BASE_ADDR) && (offset < SPAN);
    assign idx      = offset[IDX_W+1:2];
    assign fault    = (req_rd || req_wr) &&
                      ((req_rd && req_wr) || !in_range || !width_ok || !aligned);
    assign do_write = (state == ACCESS) && req_wr && !fault;

    // Width legality, alignment and store lane selection from the registered request.
    always_comb begin
        width_ok = 1'b0;
        aligned  = 1'b1;
        be       = 4'b0000;
        wr_data  = req_sdata;
        case (req_f3)
            3'b000: begin
                width_ok = 1'b1;
                be       = 4'b0001 << req_addr[1:0];
                wr_data  = {4{req_sdata[7:0]}};
            end
            3'b001: begin
                width_ok = 1'b1;
                aligned  = !req_addr[0];
                be       = req_addr[1] ? 4'b1100 : 4'b0011;
                wr_data  = {2{req_sdata[15:0]}};
            end
            3'b010: begin
                width_ok = 1'b1;
                aligned  = (req_addr[1:0] == 2'b00);
                be       = 4'b1111;
            end
            3'b100: width_ok = req_rd;
            3'b101: begin
                width_ok = req_rd;
                aligned  = !req_addr[0];
            end
            default: width_ok = 1'b0;
        endcase
    end

    // RAM is never reset; the read is issued during ACCESS and consumed in RESP.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) ram[idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
        if (state == ACCESS) rdata <= ram[idx];
    end

    always_comb begin
        shifted   = rdata >> {req_addr[1:0], 3'b000};
        load_data = rdata;
        case (req_f3)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  load_data = {24'h0, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  load_data = {16'h0, shifted[15:0]};
            default: load_data = rdata;
        endcase
    end

    // First RESP cycle latches the result; later RESP cycles wait for the handoff.
    always_comb begin
        state_nxt = state;
        ready_nxt = ready_q;
        valid_nxt = valid_q;
        wback_nxt = wback_q;
        fault_nxt = fault_q;
        wdata_nxt = wdata_q;
        case (state)
            IDLE: begin
                if (bus.i_valid) begin
                    state_nxt = ACCESS;
                    ready_nxt = 1'b0;
                end
            end
            ACCESS: state_nxt = RESP;
            RESP: begin
                if (!valid_q) begin
                    valid_nxt = 1'b1;
                    fault_nxt = fault;
                    wback_nxt = !fault && !req_wr && req_wback;
                    wdata_nxt = (req_rd && !fault) ? load_data : req_addr;
                end else if (bus.i_ready) begin
                    valid_nxt = 1'b0;
                    ready_nxt = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                ready_nxt = 1'b1;
                valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            wback_q <= 1'b0;
            fault_q <= 1'b0;
            wdata_q <= 32'h0;
        end else begin
            state   <= state_nxt;
            ready_q <= ready_nxt;
            valid_q <= valid_nxt;
            wback_q <= wback_nxt;
            fault_q <= fault_nxt;
            wdata_q <= wdata_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_pc    <= 32'h0;
            req_addr  <= 32'h0;
            req_sdata <= 32'h0;
            req_f3    <= 3'h0;
            req_rd    <= 1'b0;
            req_wr    <= 1'b0;
            req_wback <= 1'b0;
            req_wreg  <= 5'h0;
        end else if (accept) begin
            req_pc    <= bus.i_pc;
            req_addr  <= bus.i_addr;
            req_sdata <= bus.i_store_data;
            req_f3    <= bus.i_funct3;
            req_rd    <= bus.i_mem_read;
            req_wr    <= bus.i_mem_write;
            req_wback <= bus.i_wback;
            req_wreg  <= bus.i_wreg;
        end
    end

    assign bus.o_ready = ready_q;
    assign bus.o_valid = valid_q;
    assign bus.o_pc    = req_pc;
    assign bus.o_wreg  = req_wreg;
    assign bus.o_wback = wback_q;
    assign bus.o_fault = fault_q;
    assign bus.o_wdata = wdata_q;
endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage against a byte-level memory reference model.
module tb_mem_stage;
    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_2000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    logic [31:0] mem_m [DEPTH];
    logic [31:0] last_wdata;

    mem_stage_if bus();

    mem_stage #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int width_bytes(input logic [2:0] f3, input logic is_store);
        case (f3)
            3'd0: return 1;
            3'd1: return 2;
            3'd2: return 4;
            3'd4: return is_store ? 0 : 1;
            3'd5: return is_store ? 0 : 2;
            default: return 0;
        endcase
    endfunction

    // Architectural result of one request given the current model memory.
    function automatic void model(input logic [31:0] addr, input logic [2:0] f3,
                                  input logic rd, input logic wr, input logic wb,
                                  output logic [31:0] wdata, output logic wback,
                                  output logic fault, output logic do_store);
        longint unsigned a;
        int              n;
        logic [31:0]     word, v;
        a        = addr;
        wdata    = addr;
        wback    = wb;
        fault    = 1'b0;
        do_store = 1'b0;
        if (!(rd || wr)) return;
        n = width_bytes(f3, wr);
        fault = (rd && wr) || (a < BASE) || (a >= BASE + 4 * DEPTH) || (n == 0);
        if (!fault && (a % n) != 0) fault = 1'b1;
        if (fault || wr) begin
            wback    = 1'b0;
            do_store = !fault;
            return;
        end
        word = mem_m[(a - BASE) / 4];
        v    = word >> (8 * (a % 4));
        case (n)
            1: wdata = (f3 == 3'd4) ? {24'h0, v[7:0]} : {{24{v[7]}}, v[7:0]};
            2: wdata = (f3 == 3'd5) ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
            default: wdata = word;
        endcase
    endfunction

    function automatic void apply_store(input logic [31:0] addr, input logic [31:0] sd,
                                        input logic [2:0] f3);
        int          n, lane, w;
        logic [31:0] word;
        n    = width_bytes(f3, 1'b1);
        lane = addr % 4;
        w    = (addr - BASE) / 4;
        word = mem_m[w];
        for (int b = 0; b < n; b++) word[8*(lane+b) +: 8] = sd[8*b +: 8];
        mem_m[w] = word;
    endfunction

    task automatic send(input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] sd,
                        input logic [2:0] f3, input logic rd, input logic wr, input logic wb,
                        input logic [4:0] wreg, input int hold, input bit poke);
        logic [31:0] e_wdata;
        logic        e_wback, e_fault, e_store;
        int          t;
        model(addr, f3, rd, wr, wb, e_wdata, e_wback, e_fault, e_store);
        @(negedge clk);
        bus.i_valid      = 1'b1;
        bus.i_pc         = pc;
        bus.i_addr       = addr;
        bus.i_store_data = sd;
        bus.i_funct3     = f3;
        bus.i_mem_read   = rd;
        bus.i_mem_write  = wr;
        bus.i_wback      = wb;
        bus.i_wreg       = wreg;
        bus.i_ready      = 1'b0;
        t = 0;
        while (!bus.o_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("accept_ready", 32'(bus.o_ready), 32'd1);
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        check("access_ready", 32'(bus.o_ready), 32'd0);
        check("access_valid", 32'(bus.o_valid), 32'd0);
        @(posedge clk); #1;
        check("resp0_valid", 32'(bus.o_valid), 32'd0);
        @(posedge clk); #1;
        check("valid", 32'(bus.o_valid), 32'd1);
        check("wdata", bus.o_wdata, e_wdata);
        check("wback", 32'(bus.o_wback), 32'(e_wback));
        check("fault", 32'(bus.o_fault), 32'(e_fault));
        check("pc", bus.o_pc, pc);
        check("wreg", 32'(bus.o_wreg), 32'(wreg));
        last_wdata = bus.o_wdata;
        if (poke) begin
            bus.i_valid     = 1'b1;
            bus.i_pc        = ~pc;
            bus.i_addr      = BASE;
            bus.i_funct3    = 3'd2;
            bus.i_mem_read  = 1'b1;
            bus.i_mem_write = 1'b0;
        end
        for (int c = 0; c < hold; c++) begin
            @(posedge clk); #1;
            check("stall_valid", 32'(bus.o_valid), 32'd1);
            check("stall_ready", 32'(bus.o_ready), 32'd0);
            check("stall_wdata", bus.o_wdata, e_wdata);
            check("stall_pc", bus.o_pc, pc);
        end
        bus.i_ready = 1'b1;
        @(posedge clk); #1;
        bus.i_ready = 1'b0;
        bus.i_valid = 1'b0;
        check("handoff_valid", 32'(bus.o_valid), 32'd0);
        check("handoff_ready", 32'(bus.o_ready), 32'd1);
        if (poke) check("no_accept_pc", bus.o_pc, pc);
        if (e_store) apply_store(addr, sd, f3);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(bus.o_ready), 32'd1);
        check({tag, "_valid"}, 32'(bus.o_valid), 32'd0);
        check({tag, "_fault"}, 32'(bus.o_fault), 32'd0);
        check({tag, "_wback"}, 32'(bus.o_wback), 32'd0);
        check({tag, "_wreg"},  32'(bus.o_wreg),  32'd0);
        check({tag, "_pc"},    bus.o_pc,         32'd0);
        check({tag, "_wdata"}, bus.o_wdata,      32'd0);
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        case (r)
            0:       return BASE - 32'd4 + 32'($urandom_range(0, 3));
            1:       return BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 7));
            2, 3, 4, 5: return BASE + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
            6, 7, 8: return BASE + 32'(4 * $urandom_range(DEPTH - 4, DEPTH - 1)) + 32'($urandom_range(0, 3));
            default: return $urandom | 32'h8000_0000;
        endcase
    endfunction

    initial begin
        logic [31:0] a;
        int          k;
        bus.i_valid = 1'b0; bus.i_pc = '0; bus.i_addr = '0; bus.i_store_data = '0;
        bus.i_funct3 = '0; bus.i_mem_read = 1'b0; bus.i_mem_write = 1'b0;
        bus.i_wback = 1'b0; bus.i_wreg = '0; bus.i_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;

        // Seed every word the random phase can read.
        for (int w = 0; w < 8; w++)
            send(32'h100 + 32'(w), BASE + 32'(4 * w), $urandom, 3'd2, 1'b0, 1'b1, 1'b0, 5'd0, 0, 0);
        for (int w = DEPTH - 4; w < DEPTH; w++)
            send(32'h200 + 32'(w), BASE + 32'(4 * w), $urandom, 3'd2, 1'b0, 1'b1, 1'b0, 5'd0, 0, 0);

        send(32'h1000, 32'h2000, 32'hDEADBEEF, 3'd2, 1'b0, 1'b1, 1'b0, 5'd0, 0, 0);
        send(32'h1004, 32'h2000, 32'h0, 3'd2, 1'b1, 1'b0, 1'b1, 5'd5, 0, 0);
        check("lw_dir", last_wdata, 32'hDEADBEEF);
        send(32'h1008, 32'h2001, 32'h0, 3'd0, 1'b1, 1'b0, 1'b1, 5'd6, 0, 0);
        check("lb_dir", last_wdata, 32'hFFFFFFBE);
        send(32'h100C, 32'h2001, 32'h0, 3'd4, 1'b1, 1'b0, 1'b1, 5'd7, 0, 0);
        check("lbu_dir", last_wdata, 32'h000000BE);
        send(32'h1010, 32'h2002, 32'h0, 3'd1, 1'b1, 1'b0, 1'b1, 5'd8, 0, 0);
        check("lh_dir", last_wdata, 32'hFFFFDEAD);
        send(32'h1014, 32'h2002, 32'h0, 3'd5, 1'b1, 1'b0, 1'b1, 5'd9, 0, 0);
        check("lhu_dir", last_wdata, 32'h0000DEAD);
        send(32'h1018, 32'h2003, 32'h11, 3'd0, 1'b0, 1'b1, 1'b0, 5'd0, 0, 0);
        send(32'h101C, 32'h2000, 32'h0, 3'd2, 1'b1, 1'b0, 1'b1, 5'd5, 0, 0);
        check("sb_lw_dir", last_wdata, 32'h11ADBEEF);
        send(32'h1020, 32'h2000, 32'h2233, 3'd1, 1'b0, 1'b1, 1'b0, 5'd0, 0, 0);
        send(32'h1024, 32'h2000, 32'h0, 3'd2, 1'b1, 1'b0, 1'b1, 5'd5, 0, 0);
        check("sh_lw_dir", last_wdata, 32'h11AD2233);
        send(32'h1028, 32'h2002, 32'h0, 3'd2, 1'b1, 1'b0, 1'b1, 5'd5, 0, 0);
        check("misalign_wdata", last_wdata, 32'h2002);
        send(32'h102C, 32'h1FFC, 32'hFFFFFFFF, 3'd2, 1'b0, 1'b1, 1'b0, 5'd0, 0, 0);
        check("oor_wdata", last_wdata, 32'h1FFC);
        send(32'h1030, 32'h2000, 32'h0, 3'd2, 1'b1, 1'b0, 1'b1, 5'd5, 0, 0);
        check("after_fault_dir", last_wdata, 32'h11AD2233);

        send(32'h1034, 32'h2000, 32'h0, 3'd2, 1'b1, 1'b0, 1'b1, 5'd3, 4, 1);

        // Store aborted by reset while in ACCESS must leave memory untouched.
        @(negedge clk);
        bus.i_valid = 1'b1; bus.i_pc = 32'h1038; bus.i_addr = 32'h2000;
        bus.i_store_data = 32'hCAFEF00D; bus.i_funct3 = 3'd2;
        bus.i_mem_read = 1'b0; bus.i_mem_write = 1'b1; bus.i_wback = 1'b0; bus.i_wreg = 5'd0;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("postrst_valid", 32'(bus.o_valid), 32'd0);
        check("postrst_ready", 32'(bus.o_ready), 32'd1);
        send(32'h103C, 32'h2000, 32'h0, 3'd2, 1'b1, 1'b0, 1'b1, 5'd5, 0, 0);
        check("abort_lw_dir", last_wdata, 32'h11AD2233);

        send(32'h1040, BASE + 32'(4 * (DEPTH - 1)), 32'h0, 3'd2, 1'b1, 1'b0, 1'b1, 5'd4, 0, 0);
        send(32'h1044, BASE + 32'(4 * DEPTH), 32'h0, 3'd2, 1'b1, 1'b0, 1'b1, 5'd4, 0, 0);
        send(32'h1048, 32'h1234, 32'h0, 3'd0, 1'b0, 1'b0, 1'b1, 5'd12, 0, 0);
        check("passthru_dir", last_wdata, 32'h1234);

        for (int i = 0; i < 80; i++) begin
            a = rand_addr();
            k = $urandom_range(0, 7);
            send($urandom, a, $urandom, 3'($urandom_range(0, 7)),
                 (k < 4) || (k == 7), (k == 4) || (k == 5) || (k == 7),
                 1'($urandom), 5'($urandom), $urandom_range(0, 3), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
